// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer for the pipeline front end.
// Keeps at most one imem request outstanding, drops responses made stale by a
// redirect, and parks a response in a skid buffer while the hazard unit stalls.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        redirect_is_jalr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              req_q;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [XLEN-1:0]   if_instr_q, if_instr_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   tgt;
  logic [XLEN-1:0]   pc_inc;

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign flush     = flush_q;

  // Next-state, next-PC and IF/ID update; a redirect overrides everything else.
  always_comb begin
    tgt          = redirect_is_jalr ? (redirect_target & ~XLEN'(1)) : redirect_target;
    pc_inc       = pc_q + XLEN'(4);
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = stall ? if_valid_q : 1'b0;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    flush_d      = redirect_valid;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (stall) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            pc_d       = pc_inc;
            state_d    = S_REQ;
          end
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          pc_d       = pc_inc;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d         = tgt;
      if_valid_d   = 1'b0;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      case (state_q)
        S_REQ:   state_d = imem_gnt    ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ  : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_REQ  : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // State, PC, IF/ID and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      flush_q      <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= (state_d == S_REQ);
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      flush_q      <= flush_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a small instruction memory model answers requests,
// expected IF/ID PCs are queued as each scenario is driven and popped on delivery.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_is_jalr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .redirect_is_jalr (redirect_is_jalr),
    .stall            (stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .flush            (flush)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          n_deliv = 0;
  int          rsp_cnt = 0;
  int          req_cnt = 0;
  int          flush_cnt = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          last_gap = 0;
  int          rsp_delay = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory model: grants any request immediately, answers rsp_delay cycles later.
  initial begin : mem_model
    logic        gnt_prev;
    logic [31:0] addr_prev;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    gnt_prev    = 1'b0;
    addr_prev   = '0;
    pend        = 1'b0;
    cnt         = 0;
    paddr       = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rst) begin
        gnt_prev = 1'b0;
        pend     = 1'b0;
        imem_gnt = 1'b0;
      end else begin
        if (gnt_prev) begin
          pend  = 1'b1;
          paddr = addr_prev;
          cnt   = rsp_delay;
        end
        if (pend) begin
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = paddr ^ KEY;
            pend        = 1'b0;
            rsp_cnt++;
          end else begin
            cnt--;
          end
        end
        imem_gnt  = imem_req;
        addr_prev = imem_addr;
        gnt_prev  = imem_gnt;
      end
    end
  end

  // Monitor: counts flush/request cycles and scores each new IF/ID delivery.
  initial begin : monitor
    logic        prev_v;
    logic        is_new;
    logic [31:0] exp_pc;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (flush) flush_cnt++;
        if (imem_req) req_cnt++;
        is_new = if_valid && !(prev_v && stall);
        if (is_new) begin
          n_deliv++;
          last_gap = cyc - last_cyc;
          last_cyc = cyc;
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_pc = exp_q.pop_front();
            check("if_pc", if_pc, exp_pc);
            check("if_instr", if_instr, exp_pc ^ KEY);
          end
        end
        prev_v = if_valid;
      end
    end
  end

  task automatic wait_deliv(input int target, input int budget);
    for (int i = 0; i < budget && n_deliv < target; i++) tick();
    check("deliv_count", 32'(n_deliv), 32'(target));
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !imem_req; i++) tick();
    check("req_seen", 32'(imem_req), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(imem_req), 32'd0);
    check({tag, "_addr"},   imem_addr, 32'h0000_0000);
    check({tag, "_valid"},  32'(if_valid), 32'd0);
    check({tag, "_pc"},     if_pc, 32'h0);
    check({tag, "_instr"},  if_instr, 32'h0);
    check({tag, "_flush"},  32'(flush), 32'd0);
  endtask

  initial begin : main
    int disc0;
    int fl0;
    int req0;
    rst              = 1'b1;
    redirect_valid   = 1'b0;
    redirect_target  = '0;
    redirect_is_jalr = 1'b0;
    stall            = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Free run: 0, 4 at one instruction every two cycles, no flush.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    rst = 1'b0;
    wait_deliv(2, 20);
    check("deliv_gap", 32'(last_gap), 32'd2);

    // Stall for 4 cycles across the response for pc=8.
    stall = 1'b1;
    req0  = req_cnt;
    repeat (4) tick();
    check("stall_no_req", 32'(req_cnt), 32'(req0));
    check("stall_hold_valid", 32'(if_valid), 32'd1);
    check("stall_hold_pc", if_pc, 32'h4);
    stall = 1'b0;
    wait_deliv(4, 20);
    check("no_flush_freerun", 32'(flush_cnt), 32'd0);

    // Redirect to 0x200 while the granted fetch of 0x10 is in flight.
    rsp_delay = 2;
    disc0     = rsp_cnt - n_deliv;
    fl0       = flush_cnt;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 0;
    check("redir_flush", 32'(flush), 32'd1);
    check("drop_no_req", 32'(imem_req), 32'd0);
    check("drop_pc", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    wait_req(10);
    check("redir_addr", imem_addr, 32'h200);
    wait_deliv(5, 20);
    check("redir_discards", 32'(rsp_cnt - n_deliv - disc0), 32'd1);
    check("redir_flush_cnt", 32'(flush_cnt - fl0), 32'd1);

    // JALR redirect in the same cycle as the response for 0x204.
    disc0 = rsp_cnt - n_deliv;
    tick();
    redirect_valid   = 1'b1;
    redirect_target  = 32'h0000_1235;
    redirect_is_jalr = 1'b1;
    tick();
    redirect_valid   = 1'b0;
    redirect_is_jalr = 1'b0;
    check("jalr_req", 32'(imem_req), 32'd1);
    check("jalr_addr", imem_addr, 32'h1234);
    check("jalr_flush", 32'(flush), 32'd1);
    exp_q.push_back(32'h1234);
    wait_deliv(6, 20);
    check("jalr_discards", 32'(rsp_cnt - n_deliv - disc0), 32'd1);

    // Two back-to-back redirects while a stale response is outstanding.
    rsp_delay = 3;
    disc0     = rsp_cnt - n_deliv;
    fl0       = flush_cnt;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    tick();
    redirect_target = 32'h0000_0080;
    check("dbl_first_pc", imem_addr, 32'h40);
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 0;
    check("dbl_last_pc", imem_addr, 32'h80);
    exp_q.push_back(32'h80);
    wait_req(10);
    check("dbl_addr", imem_addr, 32'h80);
    wait_deliv(7, 20);
    check("dbl_discards", 32'(rsp_cnt - n_deliv - disc0), 32'd1);
    check("dbl_flush_cnt", 32'(flush_cnt - fl0), 32'd2);

    // Reset while waiting for a response, with IF/ID held valid.
    stall = 1'b1;
    tick();
    check("wait_pre_valid", 32'(if_valid), 32'd1);
    check("wait_pre_pc", if_pc, 32'h80);
    rst   = 1'b1;
    stall = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    repeat (2) tick();

    // Reset while a response sits in the skid buffer.
    exp_q.push_back(32'h0);
    rst = 1'b0;
    wait_deliv(8, 20);
    stall = 1'b1;
    repeat (2) tick();
    check("hold_no_req", 32'(imem_req), 32'd0);
    check("hold_valid", 32'(if_valid), 32'd1);
    check("hold_instr", if_instr, KEY);
    rst   = 1'b1;
    stall = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    repeat (2) tick();

    // PC wrap from 0xFFFF_FFFC back to 0.
    exp_q.push_back(32'h0);
    rst = 1'b0;
    wait_deliv(9, 20);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req", 32'(imem_req), 32'd1);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    wait_deliv(11, 20);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the pipeline front end.
- Issues one instruction-memory request at a time using a req/gnt/rvalid handshake, and presents fetched instructions to the IF/ID register.
- Applies redirects from the execute stage (taken branch, JAL, JALR) and hazard-unit stalls.
- Discards in-flight fetches made stale by a redirect, and pulses a flush to IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  execute stage requests a PC change (br_taken | is_JAL | is_JALR).
- redirect_target  in  32  target address from the ALU.
- redirect_is_jalr  in  1  clear bit 0 of the target.
- stall  in  1  hazard unit holds IF/ID; the fetched instruction must not advance.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  IF/ID contents valid.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- flush  out  1  one-cycle pulse; IF/ID and the decode stage squash.

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, if_valid=0, if_pc=0, if_instr=0, flush=0.
  - imem_addr=RESET_PC; skid buffer cleared.
  - Instruction memory shares rst, so no response survives reset.
- Effective target: tgt = redirect_is_jalr ? (redirect_target & ~32'h1) : redirect_target. No other alignment check.
- Next sequential PC: pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Outstanding requests: at most one.
- imem_addr is combinationally equal to pc.
- States:
  - IDLE: imem_req=0; go to REQ next cycle.
  - REQ: imem_req=1. On imem_gnt -> WAIT.
  - WAIT: imem_req=0; waiting for imem_rvalid.
  - DROP: imem_req=0; waiting for a stale response to discard.
  - HOLD: response captured in the skid buffer while stall=1.
- Delivery, imem_rvalid in WAIT:
  - stall=0: next cycle if_valid=1, if_pc=pc, if_instr=imem_rdata; pc<=pc+4; -> REQ.
  - stall=1: capture {pc, rdata} in the skid buffer; IF/ID outputs unchanged; -> HOLD.
- HOLD with stall=0: load the buffer into if_*, if_valid=1, pc<=pc+4, -> REQ.
- IF/ID outputs while stall=1: if_valid/if_pc/if_instr hold their values.
- IF/ID outputs while stall=0 and no delivery this cycle: if_valid<=0.
- Redirect (redirect_valid=1) has priority over stall and delivery:
  - pc<=tgt; flush=1 the next cycle; if_valid<=0; skid buffer invalidated.
  - REQ without gnt: stay in REQ; the address changes the next cycle. Retargeting before grant is legal.
  - REQ with gnt the same cycle: -> DROP.
  - WAIT without rvalid: -> DROP.
  - WAIT with rvalid the same cycle: discard the response; -> REQ.
  - DROP: pc updated; stay in DROP. Last redirect wins.
  - DROP with rvalid the same cycle: discard; -> REQ.
  - HOLD: discard the buffer; -> REQ.
  - IDLE: pc updated; -> REQ.
- DROP without redirect: on imem_rvalid, discard (if_* unaffected, pc unchanged); -> REQ.
- Latency: gnt in cycle t, rvalid in t+1 -> if_valid in t+2 and next imem_req in t+2. Steady state with a 1-cycle memory is 1 instruction per 2 cycles.
- Redirect to fetch: redirect in cycle t from WAIT-with-rvalid or REQ -> imem_req with imem_addr=tgt in t+1.

Test Plan:
- Reset then free-run, gnt immediate, rvalid 1 cycle later, instr=pc^32'hA5A5_0000 -> if_pc sequence 0,4,8,C; if_valid every other cycle; flush never.
- stall=1 for 4 cycles across rvalid at pc=8 -> no request issued; stall drop -> if_pc=8, instr intact; then fetch of C.
- Fetch of 0x10 granted, then redirect_target=0x200 before rvalid -> stale response dropped, flush pulse, next imem_addr=0x200, first if_pc=0x200.
- JALR redirect_target=0x0000_1235, is_jalr=1, in the same cycle as rvalid -> response discarded, imem_addr=0x1234 next cycle.
- Two redirects in consecutive cycles (0x40 then 0x80) while in DROP -> only 0x80 fetched; exactly one response discarded.
- Reset asserted in WAIT and in HOLD -> outputs zero immediately, imem_addr=RESET_PC; PC wrap from 32'hFFFF_FFFC -> next if_pc=0.
